// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: ID control inputs, IMEM port, ID-facing instruction slot and CSR counters.
interface if_fetch_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stall;
  logic                 id_redirect;
  logic [31:0]          id_target;
  logic                 ex_redirect;
  logic [31:0]          ex_target;
  logic [31:0]          imem_addr;
  logic                 imem_en;
  logic [31:0]          imem_rdata;
  logic [31:0]          id_pc;
  logic [31:0]          id_inst;
  logic                 id_valid;
  logic                 cnt_clear;
  logic [CNT_WIDTH-1:0] fetch_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    input  stall, id_redirect, id_target, ex_redirect, ex_target, imem_rdata, cnt_clear,
    output imem_addr, imem_en, id_pc, id_inst, id_valid, fetch_count, flush_count
  );

  modport slave (
    output stall, id_redirect, id_target, ex_redirect, ex_target, imem_rdata, cnt_clear,
    input  imem_addr, imem_en, id_pc, id_inst, id_valid, fetch_count, flush_count
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: next-PC selection, IMEM address drive, wrong-path kill and fetch/flush counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int          CNT_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.master bus
);

  logic [31:0]          pc_q, pc_d;
  logic                 live_q, live_d;
  logic [CNT_WIDTH-1:0] fetch_q, fetch_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 id_valid;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (rst)                                pc_d = RESET_PC;
    else if (bus.ex_redirect)               pc_d = {bus.ex_target[31:2], 2'b00};
    else if (bus.id_redirect && !bus.stall) pc_d = {bus.id_target[31:2], 2'b00};
    else if (bus.stall)                     pc_d = pc_q;  // re-issue so rdata repeats

    // EX redirect kills the slot now; the redirected address lands next cycle
    id_valid = live_q && !rst && !bus.ex_redirect;
    live_d   = live_q;

    fetch_d = fetch_q + CNT_WIDTH'(id_valid && !bus.stall);
    flush_d = flush_q + CNT_WIDTH'(bus.ex_redirect && !rst);
    if (bus.cnt_clear) begin
      fetch_d = '0;
      flush_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      live_q  <= 1'b1;
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      live_q  <= live_d;
      fetch_q <= fetch_d;
      flush_q <= flush_d;
    end
  end

  assign bus.imem_addr   = pc_d;
  assign bus.imem_en     = 1'b1;
  assign bus.id_pc       = pc_q;
  assign bus.id_valid    = id_valid;
  assign bus.id_inst     = id_valid ? bus.imem_rdata : NOP_INST;
  assign bus.fetch_count = fetch_q;
  assign bus.flush_count = flush_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboarded bench for if_fetch: each cycle's issued address is queued and checked at ID next cycle.
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_if #(.CNT_WIDTH(4)) bus ();

  if_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // synchronous-read IMEM model
  always @(posedge clk) bus.imem_rdata <= memf(bus.imem_addr);

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check ID slot against the scoreboard and imem_addr against exp_addr.
  task automatic step(input logic r, input logic st, input logic idr, input logic [31:0] idt,
                      input logic exr, input logic [31:0] ext, input logic clr,
                      input logic [31:0] exp_addr);
    logic [31:0] epc;
    logic        ev;
    rst = r; bus.stall = st; bus.id_redirect = idr; bus.id_target = idt;
    bus.ex_redirect = exr; bus.ex_target = ext; bus.cnt_clear = clr;
    @(negedge clk);
    ev  = !r && !exr;
    epc = 32'h0;
    if (sb_q.size() != 0) epc = sb_q.pop_front();
    else if (!r) chk("sb_empty", 32'd1, 32'd0);
    if (!r) chk("id_pc", bus.id_pc, epc);
    chk("id_valid", {31'd0, bus.id_valid}, {31'd0, ev});
    chk("id_inst", bus.id_inst, ev ? memf(epc) : NOP);
    chk("imem_addr", bus.imem_addr, exp_addr);
    sb_q.push_back(exp_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic free(input logic [31:0] exp_addr);
    step(0, 0, 0, 0, 0, 0, 0, exp_addr);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.id_redirect = 0; bus.id_target = 0;
    bus.ex_redirect = 0; bus.ex_target = 0; bus.cnt_clear = 0;

    // reset held 3 cycles
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, RST_PC);
    chk("imem_en", {31'd0, bus.imem_en}, 32'd1);
    chk("fetch_rst", {28'd0, bus.fetch_count}, 32'd0);
    chk("flush_rst", {28'd0, bus.flush_count}, 32'd0);

    // sequential fetch
    free(32'h4000_0004);
    free(32'h4000_0008);
    free(32'h4000_000C);
    free(32'h4000_0010);
    chk("fetch_seq", {28'd0, bus.fetch_count}, 32'd4);

    // reset wins over stall and id_redirect
    step(1, 1, 1, 32'h4000_0503, 0, 0, 0, RST_PC);
    chk("fetch_rst2", {28'd0, bus.fetch_count}, 32'd0);
    free(32'h4000_0004);
    free(32'h4000_0008);
    chk("fetch_pre_stall", {28'd0, bus.fetch_count}, 32'd2);

    // stall two cycles at 4000_0008
    step(0, 1, 0, 0, 0, 0, 0, 32'h4000_0008);
    step(0, 1, 0, 0, 0, 0, 0, 32'h4000_0008);
    chk("fetch_stall", {28'd0, bus.fetch_count}, 32'd2);
    free(32'h4000_000C);
    chk("fetch_post_stall", {28'd0, bus.fetch_count}, 32'd3);

    // ID redirect: zero bubbles; suppressed under stall
    step(0, 0, 1, 32'h4000_0103, 0, 0, 0, 32'h4000_0100);
    step(0, 1, 1, 32'h4000_0203, 0, 0, 0, 32'h4000_0100);
    step(0, 0, 1, 32'h4000_0203, 0, 0, 0, 32'h4000_0200);
    chk("fetch_idr", {28'd0, bus.fetch_count}, 32'd5);

    // EX redirect during stall and id_redirect: kills slot, overrides both
    step(0, 1, 1, 32'h4000_0303, 1, 32'h1000_0041, 0, 32'h1000_0040);
    chk("flush_1", {28'd0, bus.flush_count}, 32'd1);
    chk("fetch_exr", {28'd0, bus.fetch_count}, 32'd5);
    free(32'h1000_0044);
    chk("fetch_after_exr", {28'd0, bus.fetch_count}, 32'd6);

    // PC wraps past 2^32
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC);
    chk("flush_2", {28'd0, bus.flush_count}, 32'd2);
    free(32'h0000_0000);
    free(32'h0000_0004);
    chk("fetch_wrap_pc", {28'd0, bus.fetch_count}, 32'd8);

    // clear beats a same-cycle accepted fetch
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0008);
    chk("fetch_clr", {28'd0, bus.fetch_count}, 32'd0);
    chk("flush_clr", {28'd0, bus.flush_count}, 32'd0);

    // 16 accepted fetches wrap a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      free(32'h0000_000C + 32'(4 * i));
      if (i == 14) chk("fetch_15", {28'd0, bus.fetch_count}, 32'd15);
    end
    chk("fetch_wrap", {28'd0, bus.fetch_count}, 32'd0);
    free(32'h0000_004C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly upstream of the decode/control stage. Owns the fetch PC and drives the synchronous-read instruction memory, whose 1-cycle registered read data forms the IF/ID boundary. Resolves the next PC from reset, the EX-stage redirect, the ID-stage target redirect, the ID stall, and the sequential PC+4. Kills wrong-path instructions by presenting a NOP to ID, and keeps fetch/flush event counters for CSR readout.

Parameters:
RESET_PC, 32'h4000_0000, fetch address presented during reset; first instruction delivered after reset.
NOP_INST, 32'h0000_0013, instruction substituted on killed/invalid slots (addi x0,x0,0).
CNT_WIDTH, 32, width of fetch_count and flush_count.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  ID hazard stall; hold the current ID instruction.
id_redirect  in  1  ID target generator has a taken target (JAL / JALR / predicted branch).
id_target  in  32  ID redirect target.
ex_redirect  in  1  EX resolved a mispredict or late target; flush ID.
ex_target  in  32  EX redirect target.
imem_addr  out  32  combinational next-fetch byte address to IMEM.
imem_en  out  1  IMEM read enable; constant 1.
imem_rdata  in  32  IMEM data for the address presented in the previous cycle.
id_pc  out  32  PC of the instruction presented to ID (= pc_q).
id_inst  out  32  instruction to ID: imem_rdata when id_valid, else NOP_INST.
id_valid  out  1  ID slot holds a live instruction.
cnt_clear  in  1  synchronous clear of both counters.
fetch_count  out  CNT_WIDTH  instructions accepted by ID.
flush_count  out  CNT_WIDTH  EX redirects taken.

Behaviour:
- State: pc_q[31:0] (address issued last cycle), live_q (1 bit), fetch_count, flush_count.
- Next-PC mux, combinational, strict priority:
  1. rst: RESET_PC.
  2. ex_redirect: ex_target.
  3. id_redirect && !stall: id_target.
  4. stall: pc_q (re-issue, so imem_rdata repeats next cycle).
  5. Otherwise: pc_q + 4, mod 2^32, wraps silently.
- Targets from priorities 2 and 3 have bits[1:0] forced to 2'b00.
- imem_addr = next-PC; pc_q <= next-PC every cycle.
- ex_redirect overrides stall. stall suppresses id_redirect, which remains asserted upstream until the stall clears.
- Reset edge: pc_q <= RESET_PC, live_q <= 1, both counters <= 0.
- While rst=1: id_valid=0, id_inst=NOP_INST, id_pc=pc_q (don't-care).
- id_valid = live_q && !rst && !ex_redirect. An ex_redirect kills the current ID slot in the same cycle, combinationally.
- Latency: redirect or sequential address in cycle t reaches ID in cycle t+1. An ID redirect costs zero bubbles; an EX redirect costs one killed slot.
- First cycle after rst deasserts: id_pc=RESET_PC, id_inst=mem[RESET_PC], id_valid=1.
- fetch_count: +1 when id_valid && !stall.
- flush_count: +1 when ex_redirect && !rst.
- Both counters wrap at 2^CNT_WIDTH. cnt_clear wins over a same-cycle increment (result 0).
- rst mid-stall or mid-redirect: reset wins, and the next cycle fetches RESET_PC.

Test Plan:
- Reset: hold rst 3 cycles, release → imem_addr=4000_0000 during reset; cycle after release id_pc=4000_0000, id_valid=1, id_inst=mem data; counters 0.
- Sequential: 4 free cycles → id_pc 4000_0000, 0004, 0008, 000C; fetch_count=4.
- Stall: stall=1 for 2 cycles at id_pc=4000_0008 → imem_addr=4000_0008 both cycles, id_pc/id_inst held, fetch_count unchanged; after release id_pc=4000_000C.
- ID redirect: id_redirect=1, id_target=4000_0103 at id_pc=4000_0004 → imem_addr=4000_0100; next cycle id_pc=4000_0100, valid, no bubble. Same with stall=1 → imem_addr=4000_0004.
- EX redirect during stall: stall=1, ex_redirect=1, ex_target=1000_0040 → same cycle id_valid=0, id_inst=0000_0013; next cycle id_pc=1000_0040, valid; flush_count=1.
- Counters: CNT_WIDTH=4, 16 accepted fetches → fetch_count wraps to 0. cnt_clear with a same-cycle fetch → 0.
